asic_function_multichannel_interface: RTL and testbench
=======================================================

# asic_function_multichannel_interface

Parametrised successor to the single-channel ASIC function interface: accepts per-channel input samples on a valid/ready stream and drives each one to a multi-channel SPI DAC as a 16-bit addressed frame. After the DAC output settles, it triggers an ADC conversion on the matching channel and returns the result on a valid/ready output stream. It sits between the AXI register/DMA layer and the off-chip DAC/ADC pins of the hybrid DFR reservoir, serving NUM_CH reservoir nodes through one engine.

## Interface
- NUM_CH, 4: number of DAC/ADC channels, 1..16
- DATA_W, 12: DAC sample width, 1..12
- ADC_W, 16: ADC result width
- SCLK_DIV, 4: clk cycles per SCLK half-period, ≥1
- SETTLE_CYCLES, 64: DAC settle wait before conversion, ≥1
- TIMEOUT_CYCLES, 4096: ADC watchdog limit (only with ASIC_IF_TIMEOUT_EN)

Ports (CH_W = max(1, $clog2(NUM_CH))):
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid / s_ready  in/out  1  input sample handshake
- s_ch  in  CH_W  target channel
- s_data  in  DATA_W  DAC code
- m_valid / m_ready  out/in  1  result handshake
- m_ch  out  CH_W  channel of result
- m_data  out  ADC_W  ADC result
- m_err  out  1  result is a timeout (0 when feature compiled out)
- busy  out  1  engine not in IDLE
- dac_cs_n, dac_ldac_n, dac_din, dac_sclk  out  1  SPI DAC pins
- adc_convst  out  1  one-cycle conversion start
- adc_ch  out  CH_W  ADC mux select
- adc_eoc  in  1  one-cycle end-of-conversion pulse
- adc_data  in  ADC_W  result, valid in the adc_eoc cycle

## Operation
- States: IDLE → SHIFT → CS_GAP → LDAC → SETTLE → CONVST → WAIT_EOC → OUT → IDLE.
- s_ready = (state == IDLE).
- On accept, latch s_ch and s_data. Frame = {4'(s_ch), s_data, (12−DATA_W)'0}, sent MSB first.
- If s_ch ≥ NUM_CH, the request is accepted and discarded: stay in IDLE, no pin activity, no result.
- SHIFT: dac_cs_n=0. Each bit holds dac_sclk=0 for SCLK_DIV cycles, then 1 for SCLK_DIV cycles. dac_din changes only while dac_sclk is low; the DAC samples on the rising edge.
- CS_GAP: dac_cs_n=1, dac_sclk=0 for SCLK_DIV cycles.
- LDAC: dac_ldac_n=0 for SCLK_DIV cycles.
- SETTLE: count SETTLE_CYCLES.
- CONVST: adc_convst=1 for exactly 1 cycle.
- WAIT_EOC: on adc_eoc, capture adc_data into m_data.
- OUT: m_valid=1 with m_ch = latched channel; hold until m_ready, then return to IDLE.
- adc_ch = latched channel, stable from accept through OUT.
- adc_eoc outside WAIT_EOC is ignored.
- adc_eoc in the CONVST cycle itself is ignored.

## Timing
- Reset values: m_valid=0, m_data=0, m_ch=0, m_err=0, busy=0, dac_cs_n=1, dac_ldac_n=1, dac_din=0, dac_sclk=0, adc_convst=0, adc_ch=0. s_ready=1 from the first cycle after reset.
- Reset mid-operation: on the next edge all outputs return to reset values. The partial frame is abandoned, and a pending result is dropped.
- Accept at cycle 0 (s_valid && s_ready):
  - dac_cs_n falls at cycle 1.
  - dac_cs_n rises at 1+32·SCLK_DIV.
  - dac_ldac_n is low over [1+33·D, 1+34·D), where D = SCLK_DIV.
  - adc_convst is high at cycle 1+34·D+SETTLE_CYCLES.
- adc_eoc at cycle E gives m_valid=1 at E+1.
- m_data and m_ch stay stable while m_valid && !m_ready.
- Minimum request spacing: the accept cycle after m_valid && m_ready is the following cycle, with one IDLE cycle between transactions.
- Throughput is one transaction at a time; there is no input buffering.

## Configuration
- ASIC_IF_TIMEOUT_EN defined: a WAIT_EOC counter runs. At TIMEOUT_CYCLES cycles without adc_eoc, go to OUT with m_data = all ones and m_err=1. adc_eoc in the same cycle as expiry wins: normal result, m_err=0.
- Not defined: WAIT_EOC waits indefinitely; m_err is tied to 0 and the counter is absent.

## Structure
- Package asic_if_pkg holds:
  - state enum
  - FRAME_W=16
  - ADDR_W=4
  - MAX_DATA_W=12
  - frame-packing function
- Sub-module dac_spi_serializer: frame + start in; cs_n, sclk, din, done out; parameter SCLK_DIV. Owns the SHIFT bit and half-period counters.
- Top FSM owns CS_GAP through OUT, the settle/timeout counter and the output register.

## Test plan
- NUM_CH=4, SCLK_DIV=2, s_ch=2, s_data=12'hABC → DIN bits 0x2ABC MSB-first on 16 SCLK rising edges; LDAC low 2 cycles; CONVST at cycle 1+68+SETTLE.
- adc_eoc with adc_data=16'h1234 → next cycle m_valid=1, m_data=16'h1234, m_ch=2, m_err=0.
- m_ready held low 10 cycles after m_valid → outputs stable, s_ready=0, no pin activity; accept possible 1 cycle after the m_ready handshake.
- s_ch=5 with NUM_CH=4 → accepted, dac_cs_n stays 1, no m_valid; the next valid request proceeds normally.
- rst asserted mid-SHIFT (bit 7) → next edge dac_cs_n=1, dac_sclk=0, busy=0, s_ready=1; stray adc_eoc afterwards is ignored.
- With ASIC_IF_TIMEOUT_EN, TIMEOUT_CYCLES=16, no adc_eoc → m_valid at CONVST+17, m_data=16'hFFFF, m_err=1; adc_eoc coinciding with expiry → normal data, m_err=0.

Source files
------------

// File: rtl/asic_if_pkg.sv
// Shared types and helpers for the multichannel DAC/ADC function interface.
package asic_if_pkg;

  localparam int FRAME_W    = 16;
  localparam int ADDR_W     = 4;
  localparam int MAX_DATA_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CS_GAP,
    ST_LDAC,
    ST_SETTLE,
    ST_CONVST,
    ST_WAIT_EOC,
    ST_OUT
  } state_e;

  // DAC frame: 4-bit channel address followed by the MSB-aligned code.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [ADDR_W-1:0]     addr,
                                                    input logic [MAX_DATA_W-1:0] code);
    return {addr, code};
  endfunction

endpackage

// File: rtl/asic_function_multichannel_interface_dac_spi_serializer.sv
// SPI shifter: sends one 16-bit frame MSB first, SCLK_DIV cycles per SCLK half-period.
// cs_n falls the cycle after start; done pulses in the last high half-period.
module dac_spi_serializer
  import asic_if_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               cs_n_o,
  output logic               sclk_o,
  output logic               din_o,
  output logic               done_o
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic               active_q;
  logic               sclk_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [3:0]         bit_q;
  logic [DIV_W-1:0]   div_q;
  logic               half_end;
  logic               last_bit;

  assign half_end = (div_q == DIV_W'(SCLK_DIV - 1));
  assign last_bit = (bit_q == 4'(FRAME_W - 1));
  assign done_o   = active_q && sclk_q && half_end && last_bit;

  assign cs_n_o = !active_q;
  assign sclk_o = sclk_q;
  assign din_o  = active_q && shreg_q[FRAME_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      shreg_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
    end else if (start_i && !active_q) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      shreg_q  <= frame_i;
      bit_q    <= '0;
      div_q    <= '0;
    end else if (active_q) begin
      if (half_end) begin
        div_q  <= '0;
        sclk_q <= !sclk_q;
        // Advance data only as SCLK falls so DIN is stable across the rising edge.
        if (sclk_q) begin
          shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
          bit_q   <= bit_q + 4'd1;
          if (last_bit) begin
            active_q <= 1'b0;
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/asic_function_multichannel_interface.sv
// One-at-a-time DAC write / settle / ADC convert engine over NUM_CH channels; s_ready only in IDLE,
// result held on m_* until m_ready. Define ASIC_IF_TIMEOUT_EN to enable the ADC end-of-conversion watchdog.
module asic_function_multichannel_interface
  import asic_if_pkg::*;
#(
  parameter int  NUM_CH         = 4,
  parameter int  DATA_W         = 12,
  parameter int  ADC_W          = 16,
  parameter int  SCLK_DIV       = 4,
  parameter int  SETTLE_CYCLES  = 64,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CH_W-1:0]   m_ch,
  output logic [ADC_W-1:0]  m_data,
  output logic              m_err,
  output logic              busy,
  output logic              dac_cs_n,
  output logic              dac_ldac_n,
  output logic              dac_din,
  output logic              dac_sclk,
  output logic              adc_convst,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_eoc,
  input  logic [ADC_W-1:0]  adc_data
);

  localparam int CNT_MAX0 = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > SCLK_DIV) ? CNT_MAX0 : SCLK_DIV;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ADC_W-1:0]      data_q, data_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  ch_ok;
  logic                  ser_start;
  logic                  ser_done;
  logic [MAX_DATA_W-1:0] code_aligned;
  logic [FRAME_W-1:0]    frame;

  assign accept       = s_valid && (state_q == ST_IDLE);
  assign ch_ok        = (32'(s_ch) < 32'(NUM_CH));
  assign ser_start    = accept && ch_ok;
  assign code_aligned = MAX_DATA_W'(s_data) << (MAX_DATA_W - DATA_W);
  assign frame        = pack_frame(4'(s_ch), code_aligned);

  dac_spi_serializer #(
    .SCLK_DIV (SCLK_DIV)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start_i (ser_start),
    .frame_i (frame),
    .cs_n_o  (dac_cs_n),
    .sclk_o  (dac_sclk),
    .din_o   (dac_din),
    .done_o  (ser_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // Out-of-range channels are consumed here and never reach the pins.
        if (ser_start) begin
          state_d = ST_SHIFT;
          ch_d    = s_ch;
        end
      end
      ST_SHIFT: begin
        if (ser_done) begin
          state_d = ST_CS_GAP;
          cnt_d   = '0;
        end
      end
      ST_CS_GAP: begin
        if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
          state_d = ST_LDAC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LDAC: begin
        if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CONVST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CONVST: begin
        state_d = ST_WAIT_EOC;
        cnt_d   = '0;
      end
      ST_WAIT_EOC: begin
        if (adc_eoc) begin
          state_d = ST_OUT;
          data_d  = adc_data;
          err_d   = 1'b0;
        end
`ifdef ASIC_IF_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_OUT;
          data_d  = '1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
`endif
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready    = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dac_ldac_n = (state_q != ST_LDAC);
  assign adc_convst = (state_q == ST_CONVST);
  assign adc_ch     = ch_q;
  assign m_valid    = (state_q == ST_OUT);
  assign m_ch       = ch_q;
  assign m_data     = data_q;
  assign m_err      = err_q;

endmodule

// File: tb/tb_asic_function_multichannel_interface.sv
// Randomised scoreboard bench: the driver pushes expected pin timing and results, two monitors check them.
module tb_asic_function_multichannel_interface;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 12;
  localparam int ADC_W  = 16;
  localparam int D      = 2;
  localparam int S      = 8;
  localparam int TO     = 16;
  localparam int CH_W   = 3;
`ifdef ASIC_IF_TIMEOUT_EN
  localparam int MAX_EOC = TO;
`else
  localparam int MAX_EOC = 30;
`endif

  typedef struct {
    logic [15:0] frame;
    int t_csfall, t_csrise, t_ldlo, t_ldhi, t_conv, ch;
  } pin_rec_t;

  typedef struct {
    int t_valid, ch;
    logic [15:0] data;
    logic err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, m_ready = 1'b0, adc_eoc = 1'b0;
  logic [CH_W-1:0] s_ch = '0;
  logic [DATA_W-1:0] s_data = '0;
  logic [ADC_W-1:0] adc_data = '0;
  logic s_ready, m_valid, m_err, busy, dac_cs_n, dac_ldac_n, dac_din, dac_sclk, adc_convst;
  logic [CH_W-1:0] m_ch, adc_ch;
  logic [ADC_W-1:0] m_data;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  pin_rec_t exp_pin[$];
  res_t exp_res[$];

  asic_function_multichannel_interface #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADC_W(ADC_W), .SCLK_DIV(D),
    .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_data(m_data), .m_err(m_err), .busy(busy),
    .dac_cs_n(dac_cs_n), .dac_ldac_n(dac_ldac_n), .dac_din(dac_din), .dac_sclk(dac_sclk),
    .adc_convst(adc_convst), .adc_ch(adc_ch), .adc_eoc(adc_eoc), .adc_data(adc_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int p);
    while (cyc < p) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_cs_n"}, int'(dac_cs_n), 1);
    chk({tag, "_sclk"}, int'(dac_sclk), 0);
    chk({tag, "_din"}, int'(dac_din), 0);
    chk({tag, "_ldac_n"}, int'(dac_ldac_n), 1);
    chk({tag, "_convst"}, int'(adc_convst), 0);
    chk({tag, "_adc_ch"}, int'(adc_ch), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 1);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_data"}, int'(m_data), 0);
    chk({tag, "_m_ch"}, int'(m_ch), 0);
    chk({tag, "_m_err"}, int'(m_err), 0);
  endtask

  // Drive s_valid; returns the acceptance cycle, pushing the expected pin record for valid channels.
  task automatic offer(input int ch, input logic [11:0] data, output int a);
    pin_rec_t pr;
    int t;
    s_valid = 1'b1;
    s_ch = CH_W'(ch);
    s_data = data;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_immediate", t, 0);
    a = cyc;
    if (ch < NUM_CH && s_ready) begin
      pr.frame    = 16'((ch << 12) | (int'(data) << (12 - DATA_W)));
      pr.t_csfall = a + 1;
      pr.t_csrise = a + 1 + 32 * D;
      pr.t_ldlo   = a + 1 + 33 * D;
      pr.t_ldhi   = a + 1 + 34 * D;
      pr.t_conv   = a + 1 + 34 * D + S;
      pr.ch       = ch;
      exp_pin.push_back(pr);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // eoc_dly = 0 means no end-of-conversion at all (watchdog build only).
  task automatic send(input int ch, input logic [11:0] data, input bit stray, input int eoc_dly,
                      input int rdy_dly, input logic [15:0] adcv);
    int a, tc, tv;
    res_t rr;
    offer(ch, data, a);
    if (ch >= NUM_CH) return;
    tc = a + 1 + 34 * D + S;
    if (stray) begin
      goto(tc - 2);
      adc_eoc = 1'b1; adc_data = 16'($urandom);
      goto(tc - 1);
      adc_eoc = 1'b0;
      goto(tc);
      adc_eoc = 1'b1; adc_data = 16'($urandom);
    end
    goto(tc + 1);
    adc_eoc = 1'b0;
    rr.ch = ch;
    if (eoc_dly > 0) begin
      goto(tc + eoc_dly);
      adc_eoc = 1'b1;
      adc_data = adcv;
      tv = tc + eoc_dly + 1;
      rr.data = adcv;
      rr.err = 1'b0;
    end else begin
      tv = tc + TO + 1;
      rr.data = 16'hFFFF;
      rr.err = 1'b1;
    end
    rr.t_valid = tv;
    exp_res.push_back(rr);
    goto(tc + eoc_dly + 1);
    adc_eoc = 1'b0;
    goto(tv + rdy_dly);
    m_ready = 1'b1;
    goto(tv + rdy_dly + 1);
    m_ready = 1'b0;
  endtask

  // Pin monitor: reconstructs the SPI frame and pin timing, compared on each CONVST pulse.
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_din = 1'b0, prev_ld = 1'b1, prev_cv = 1'b0;
  logic [15:0] shv = '0;
  int nbits = 0, t_csf = 0, t_csr = 0, t_ldl = 0, t_ldh = 0;
  always @(negedge clk) begin
    pin_rec_t e;
    if (rst) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_din = 1'b0; prev_ld = 1'b1; prev_cv = 1'b0;
      nbits = 0; shv = '0;
    end else begin
      if (prev_cs && !dac_cs_n) begin
        t_csf = cyc; nbits = 0; shv = '0;
        chk("frame_expected", int'(exp_pin.size() > 0), 1);
      end
      if (dac_cs_n && dac_sclk) chk("sclk_idle_low", int'(dac_sclk), 0);
      if (!dac_cs_n && dac_sclk && !prev_sclk) begin
        shv = {shv[14:0], dac_din};
        nbits++;
      end
      if (dac_sclk && prev_sclk) chk("din_stable_sclk_high", int'(dac_din), int'(prev_din));
      if (!prev_cs && dac_cs_n) t_csr = cyc;
      if (prev_ld && !dac_ldac_n) t_ldl = cyc;
      if (!prev_ld && dac_ldac_n) t_ldh = cyc;
      if (adc_convst) begin
        chk("convst_single_cycle", int'(prev_cv), 0);
        chk("convst_expected", int'(exp_pin.size() > 0), 1);
        if (exp_pin.size() > 0) begin
          e = exp_pin.pop_front();
          chk("din_frame", int'(shv), int'(e.frame));
          chk("sclk_rises", nbits, 16);
          chk("cs_fall_cycle", t_csf, e.t_csfall);
          chk("cs_rise_cycle", t_csr, e.t_csrise);
          chk("ldac_low_cycle", t_ldl, e.t_ldlo);
          chk("ldac_high_cycle", t_ldh, e.t_ldhi);
          chk("convst_cycle", cyc, e.t_conv);
          chk("adc_ch", int'(adc_ch), e.ch);
        end
      end
      prev_cs = dac_cs_n; prev_sclk = dac_sclk; prev_din = dac_din;
      prev_ld = dac_ldac_n; prev_cv = adc_convst;
    end
  end

  // Result monitor: checks valid timing, hold stability and the delivered result.
  logic prev_mv = 1'b0, prev_mr = 1'b0, prev_merr = 1'b0;
  logic [ADC_W-1:0] prev_md = '0;
  logic [CH_W-1:0] prev_mch = '0;
  always @(negedge clk) begin
    res_t r;
    if (rst) begin
      prev_mv = 1'b0; prev_mr = 1'b0;
    end else begin
      if (m_valid && !prev_mv) begin
        chk("result_expected", int'(exp_res.size() > 0), 1);
        if (exp_res.size() > 0) chk("m_valid_cycle", cyc, exp_res[0].t_valid);
      end
      if (m_valid) chk("s_ready_while_out", int'(s_ready), 0);
      if (m_valid && prev_mv && !prev_mr) begin
        chk("hold_m_data", int'(m_data), int'(prev_md));
        chk("hold_m_ch", int'(m_ch), int'(prev_mch));
        chk("hold_m_err", int'(m_err), int'(prev_merr));
      end
      if (m_valid && m_ready && exp_res.size() > 0) begin
        r = exp_res.pop_front();
        chk("m_data", int'(m_data), int'(r.data));
        chk("m_ch", int'(m_ch), r.ch);
        chk("m_err", int'(m_err), int'(r.err));
      end
      prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data; prev_mch = m_ch; prev_merr = m_err;
    end
  end

  initial begin
    int a;
    repeat (3) @(posedge clk);
    #1;
    check_reset("init");
    @(posedge clk); #1;
    rst = 1'b0;

    send(2, 12'hABC, 1'b0, 5, 0, 16'h1234);
    send(1, 12'h5A5, 1'b0, 3, 10, 16'hBEEF);
    send(5, 12'h777, 1'b0, 1, 0, 16'h0000);
    goto(cyc + 40);
    send(4, 12'h001, 1'b1, 2, 1, 16'hC0DE);
    send(0, 12'hFFF, 1'b1, 1, 0, 16'h8001);

    offer(3, 12'h3C3, a);
    goto(a + 1 + 14 * D + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("midshift");
    exp_pin.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    goto(cyc + 2);
    adc_eoc = 1'b1; adc_data = 16'hDEAD;
    goto(cyc + 1);
    adc_eoc = 1'b0;
    goto(cyc + 6);

`ifdef ASIC_IF_TIMEOUT_EN
    send(3, 12'h246, 1'b0, 0, 2, 16'h0000);
    send(2, 12'h135, 1'b0, TO, 0, 16'h1357);
`endif

    for (int i = 0; i < 24; i++) begin
      send($urandom_range(0, 6), 12'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(1, MAX_EOC), $urandom_range(0, 3), 16'($urandom));
    end

    goto(cyc + 10);
    chk("pin_queue_drained", exp_pin.size(), 0);
    chk("result_queue_drained", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
